// File: rtl/lzc_pipe.sv
// Leading/trailing zero/one counter, two-stage elastic pipeline (normalise, then binary search).
// Latency: operand presented in cycle t yields out_valid in cycle t+2; one result per cycle.
// Backpressure: out_ready=0 with both stages full drops in_ready; outputs hold until taken.
module lzc_pipe #(
    parameter int DATAWIDTH = 32,
    parameter int CNTW      = $clog2(DATAWIDTH) + 1
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DATAWIDTH-1:0] in_data,
    input  logic [1:0]           in_mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATAWIDTH-1:0] out_cnt,
    output logic                 out_full
);

    localparam int LVL = $clog2(DATAWIDTH);

    logic                 s1_valid;
    logic [DATAWIDTH-1:0] s1_u;
    logic                 s2_valid;
    logic [CNTW-1:0]      s2_cnt;
    logic                 s2_full;

    logic                 s2_load;
    logic                 in_xfer;
    logic [DATAWIDTH-1:0] inv;
    logic [DATAWIDTH-1:0] norm;
    logic [DATAWIDTH-1:0] win;
    logic [CNTW-1:0]      acc;
    logic [CNTW-1:0]      search_cnt;
    logic                 search_full;

    assign s2_load  = !s2_valid || out_ready;
    // Gated by resetn so no operand is offered acceptance while reset is held.
    assign in_ready = resetn && (!s1_valid || s2_load);
    assign in_xfer  = in_valid && in_ready;

    // Mode bit 0 selects ones (invert), bit 1 selects trailing (bit-reverse).
    always_comb begin
        inv  = in_data ^ {DATAWIDTH{in_mode[0]}};
        norm = inv;
        if (in_mode[1]) begin
            for (int i = 0; i < DATAWIDTH; i++) begin
                norm[i] = inv[DATAWIDTH-1-i];
            end
        end
    end

    // The live window is always kept left-aligned in win, so its upper half is the top bits.
    always_comb begin
        win = s1_u;
        acc = '0;
        for (int k = 0; k < LVL; k++) begin
            if ((win >> (DATAWIDTH - (DATAWIDTH >> (k + 1)))) == '0) begin
                acc = acc + CNTW'(DATAWIDTH >> (k + 1));
                win = win << (DATAWIDTH >> (k + 1));
            end
        end
        search_cnt  = acc + {{(CNTW-1){1'b0}}, ~win[DATAWIDTH-1]};
        search_full = (s1_u == '0);
    end

    always_ff @(posedge clk) begin
        if (in_xfer) begin
            s1_u <= norm;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            s2_cnt   <= '0;
            s2_full  <= 1'b0;
        end else begin
            if (in_xfer) begin
                s1_valid <= 1'b1;
            end else if (s2_load) begin
                s1_valid <= 1'b0;
            end
            if (s2_load) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    s2_cnt  <= search_cnt;
                    s2_full <= search_full;
                end
            end
        end
    end

    assign out_valid = s2_valid;
    assign out_cnt   = {{(DATAWIDTH-CNTW){1'b0}}, s2_cnt};
    assign out_full  = s2_full;

endmodule
